// File: rtl/dshot_arming_controller_if.sv
// Decoded-frame input bundle and motor-facing outputs of the DShot arming
// controller. The frame receiver side is the master; the controller is the slave.
interface dshot_arming_controller_if;
   // frame_strobe is a one-cycle qualifier: the data fields are only meaningful
   // in a cycle where it is high, and every high cycle is a distinct frame
   // (there is no ready/back-pressure; the controller accepts every strobe).
   logic        frame_strobe;
   logic [10:0] set_speed;
   logic [5:0]  special_command;
   logic        is_special_command;
   logic        crc_valid;
   logic [10:0] throttle;
   logic        armed;
   logic        failsafe;
   logic        cmd_strobe;
   logic [5:0]  cmd_code;
   logic [1:0]  state;

   modport master (
      output frame_strobe, set_speed, special_command, is_special_command, crc_valid,
      input  throttle, armed, failsafe, cmd_strobe, cmd_code, state
   );

   modport slave (
      input  frame_strobe, set_speed, special_command, is_special_command, crc_valid,
      output throttle, armed, failsafe, cmd_strobe, cmd_code, state
   );
endinterface

// File: rtl/dshot_arming_controller.sv
// DShot arming controller: turns decoded frames into a safe throttle.
// Handles the zero-frame arming sequence, command qualification by repetition,
// link-loss timeout and CRC-error bursts. All outputs come straight from flops.
module dshot_arming_controller #(
   parameter int ARM_FRAMES     = 10,
   parameter int CMD_REPEAT     = 6,
   parameter int TIMEOUT_CYCLES = 16000,
   parameter int ERR_LIMIT      = 4
) (
   input logic                      clk,
   input logic                      reset_n,
   dshot_arming_controller_if.slave bus
);

   localparam logic [1:0] ST_DISARMED = 2'b00;
   localparam logic [1:0] ST_ARMED    = 2'b01;
   localparam logic [1:0] ST_FAILSAFE = 2'b10;

   localparam int AW = $clog2(ARM_FRAMES + 1);
   localparam int CW = $clog2(CMD_REPEAT + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int EW = $clog2(ERR_LIMIT + 1);

   localparam logic [AW-1:0] ARM_LAST = AW'(ARM_FRAMES - 1);
   localparam logic [CW-1:0] CMD_LAST = CW'(CMD_REPEAT - 1);
   localparam logic [CW-1:0] CMD_MAX  = CW'(CMD_REPEAT);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);
   localparam logic [EW-1:0] ERR_LAST = EW'(ERR_LIMIT - 1);

   logic [1:0]    r_state;
   logic [10:0]   r_throttle;
   logic [AW-1:0] r_arm_cnt;
   logic [EW-1:0] r_err_cnt;
   logic [TW-1:0] r_to_cnt;
   logic [CW-1:0] r_cmd_cnt;
   logic [5:0]    r_cmd_prev;
   logic [5:0]    r_cmd_code;
   logic          r_cmd_strobe;

   logic [1:0]    w_state_nxt;
   logic [10:0]   w_throttle_nxt;
   logic [AW-1:0] w_arm_cnt_nxt;
   logic [EW-1:0] w_err_cnt_nxt;
   logic [TW-1:0] w_to_cnt_nxt;
   logic [CW-1:0] w_cmd_cnt_nxt;
   logic [5:0]    w_cmd_prev_nxt;
   logic [5:0]    w_cmd_code_nxt;
   logic          w_cmd_strobe_nxt;

   // Frame classification
   logic w_vf, w_bf, w_zf, w_sf, w_cf, w_timeout, w_qualify;
   assign w_vf = bus.frame_strobe & bus.crc_valid;
   assign w_bf = bus.frame_strobe & ~bus.crc_valid;
   assign w_zf = w_vf & bus.is_special_command & (bus.special_command == 6'd0);
   assign w_sf = w_vf & ~bus.is_special_command;
   assign w_cf = w_vf & bus.is_special_command & (bus.special_command != 6'd0)
               & (bus.special_command < 6'd48);
   // A valid frame in the cycle the timer would expire wins over the timeout.
   assign w_timeout = ~w_vf & (r_to_cnt == TO_LAST);
   // Commands are only acted on while the motor cannot be spinning.
   assign w_qualify = (r_state == ST_DISARMED) | ((r_state == ST_ARMED) & (r_throttle == 11'd0));

   // Link timer, arming/error counters, state and throttle next values
   always_comb begin
      w_to_cnt_nxt   = r_to_cnt;
      w_state_nxt    = r_state;
      w_throttle_nxt = r_throttle;
      w_arm_cnt_nxt  = r_arm_cnt;
      w_err_cnt_nxt  = r_err_cnt;

      if (w_vf)
         w_to_cnt_nxt = '0;
      else if (r_to_cnt != TO_MAX)
         w_to_cnt_nxt = r_to_cnt + TW'(1);

      case (r_state)
         ST_DISARMED: begin
            w_throttle_nxt = 11'd0;
            if (w_zf) begin
               if (r_arm_cnt == ARM_LAST) begin
                  w_state_nxt   = ST_ARMED;
                  w_arm_cnt_nxt = '0;
               end else begin
                  w_arm_cnt_nxt = r_arm_cnt + AW'(1);
               end
            end else if (w_vf | w_bf | w_timeout) begin
               w_arm_cnt_nxt = '0;
            end
         end
         ST_ARMED: begin
            if (w_vf) w_err_cnt_nxt = '0;
            if (w_sf) w_throttle_nxt = bus.set_speed;
            if (w_zf) w_throttle_nxt = 11'd0;
            if (w_bf) begin
               if (r_err_cnt == ERR_LAST) begin
                  w_state_nxt    = ST_FAILSAFE;
                  w_throttle_nxt = 11'd0;
                  w_err_cnt_nxt  = '0;
               end else begin
                  w_err_cnt_nxt = r_err_cnt + EW'(1);
               end
            end
            if (w_timeout) begin
               w_state_nxt    = ST_FAILSAFE;
               w_throttle_nxt = 11'd0;
               w_err_cnt_nxt  = '0;
            end
         end
         ST_FAILSAFE: begin
            w_throttle_nxt = 11'd0;
            if (w_zf) begin
               w_state_nxt   = ST_DISARMED;
               w_arm_cnt_nxt = '0;
            end
         end
         default: begin
            w_state_nxt    = ST_DISARMED;
            w_throttle_nxt = 11'd0;
            w_arm_cnt_nxt  = '0;
            w_err_cnt_nxt  = '0;
         end
      endcase
   end

   // Command qualification: a run of identical codes fires once at CMD_REPEAT
   always_comb begin
      w_cmd_cnt_nxt    = r_cmd_cnt;
      w_cmd_prev_nxt   = r_cmd_prev;
      w_cmd_code_nxt   = r_cmd_code;
      w_cmd_strobe_nxt = 1'b0;

      if ((w_state_nxt != r_state) | w_sf | w_zf | w_bf) begin
         w_cmd_cnt_nxt = '0;
      end else if (w_cf & w_qualify) begin
         if ((r_cmd_cnt != '0) & (bus.special_command == r_cmd_prev)) begin
            // Saturated runs hold silently until broken.
            if (r_cmd_cnt != CMD_MAX) begin
               w_cmd_cnt_nxt = r_cmd_cnt + CW'(1);
               if (r_cmd_cnt == CMD_LAST) begin
                  w_cmd_strobe_nxt = 1'b1;
                  w_cmd_code_nxt   = bus.special_command;
               end
            end
         end else begin
            w_cmd_cnt_nxt  = CW'(1);
            w_cmd_prev_nxt = bus.special_command;
            if (CMD_REPEAT == 1) begin
               w_cmd_strobe_nxt = 1'b1;
               w_cmd_code_nxt   = bus.special_command;
            end
         end
      end
   end

   // State register with asynchronous clear to the safe, disarmed condition
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_DISARMED;
         r_throttle   <= 11'd0;
         r_arm_cnt    <= '0;
         r_err_cnt    <= '0;
         r_to_cnt     <= '0;
         r_cmd_cnt    <= '0;
         r_cmd_prev   <= 6'd0;
         r_cmd_code   <= 6'd0;
         r_cmd_strobe <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_throttle   <= w_throttle_nxt;
         r_arm_cnt    <= w_arm_cnt_nxt;
         r_err_cnt    <= w_err_cnt_nxt;
         r_to_cnt     <= w_to_cnt_nxt;
         r_cmd_cnt    <= w_cmd_cnt_nxt;
         r_cmd_prev   <= w_cmd_prev_nxt;
         r_cmd_code   <= w_cmd_code_nxt;
         r_cmd_strobe <= w_cmd_strobe_nxt;
      end
   end

   // State encoding is one-hot-ish, so armed/failsafe are direct flop bits.
   assign bus.state      = r_state;
   assign bus.armed      = r_state[0];
   assign bus.failsafe   = r_state[1];
   assign bus.throttle   = r_throttle;
   assign bus.cmd_strobe = r_cmd_strobe;
   assign bus.cmd_code   = r_cmd_code;

endmodule
